// File: rtl/usf_dac_stream.sv
// Output-FIFO reader that converts signed 16-bit recovered samples to 12-bit offset binary
// and ships one 16-bit {cmd, code} SPI frame per sample tick to an external DAC.
module usf_dac_stream #(
  parameter int unsigned SCK_HALF      = 2,
  parameter int unsigned SAMPLE_PERIOD = 2500,
  parameter logic [3:0]  DAC_CMD       = 4'b0011
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] fifo_out_readdata,
  input  logic        fifo_out_empty,
  output logic        fifo_out_read,
  output logic        sck,
  output logic        cs,
  output logic        din,
  output logic        underrun,
  output logic        overrun,
  output logic [11:0] last_code
);

  localparam int unsigned TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned HW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam logic [TW-1:0] TickLast = TW'(SAMPLE_PERIOD - 1);
  localparam logic [HW-1:0] HalfLast = HW'(SCK_HALF - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StCapture, StShift, StTail} state_e;

  state_e             state_q;
  logic [TW-1:0]      tick_cnt_q;
  logic               tick;
  logic [HW-1:0]      half_cnt_q;
  logic [3:0]         bit_cnt_q;
  logic [15:0]        shreg_q;
  logic               use_last_q;
  logic signed [15:0] sample;
  logic [11:0]        code;
  logic               unused_upper;

  assign unused_upper = ^fifo_out_readdata[31:16];

  always_ff @(posedge clk) begin
    if (reset || !en || tick_cnt_q == TickLast) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TW'(1);
    end
  end

  assign tick = en && (tick_cnt_q == TickLast);

  // Saturate to the 12-bit range, then flip the sign bit to get offset binary.
  always_comb begin
    sample = fifo_out_readdata[15:0];
    code   = {~sample[11], sample[10:0]};
    if (use_last_q) begin
      code = last_code;
    end else if (sample > 16'sd2047) begin
      code = 12'hFFF;
    end else if (sample < -16'sd2048) begin
      code = 12'h000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      fifo_out_read <= 1'b0;
      sck           <= 1'b0;
      cs            <= 1'b1;
      din           <= 1'b0;
      underrun      <= 1'b0;
      overrun       <= 1'b0;
      last_code     <= 12'h800;
      half_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      use_last_q    <= 1'b0;
    end else begin
      fifo_out_read <= 1'b0;
      if (tick && state_q != StIdle) begin
        overrun <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (tick) begin
            if (!fifo_out_empty) begin
              fifo_out_read <= 1'b1;
              use_last_q    <= 1'b0;
              state_q       <= StFetch;
            end else begin
              underrun   <= 1'b1;
              use_last_q <= 1'b1;
              state_q    <= StCapture;
            end
          end
        end
        StFetch: state_q <= StCapture;
        StCapture: begin
          shreg_q    <= {DAC_CMD, code};
          last_code  <= code;
          cs         <= 1'b0;
          sck        <= 1'b0;
          din        <= DAC_CMD[3];
          half_cnt_q <= '0;
          bit_cnt_q  <= '0;
          state_q    <= StShift;
        end
        StShift: begin
          if (half_cnt_q == HalfLast) begin
            half_cnt_q <= '0;
            if (!sck) begin
              sck <= 1'b1;
            end else begin
              sck <= 1'b0;
              // Next bit goes out at the start of the low phase.
              if (bit_cnt_q == 4'd15) begin
                state_q <= StTail;
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
                shreg_q   <= {shreg_q[14:0], 1'b0};
                din       <= shreg_q[14];
              end
            end
          end else begin
            half_cnt_q <= half_cnt_q + HW'(1);
          end
        end
        StTail: begin
          if (half_cnt_q == HalfLast) begin
            cs      <= 1'b1;
            din     <= 1'b0;
            state_q <= StIdle;
          end else begin
            half_cnt_q <= half_cnt_q + HW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/usf_dac_stream.md
Name: usf_dac_stream

Overview:
- Output-side reader of the recovery output FIFO: pops 32-bit words written by the USF top level and converts the signed 16-bit recovered sample to 12-bit offset binary.
- Transmits each sample to an external 12-bit SPI DAC, one frame per sample tick.
- Acts as the DAC-facing transmitter, the counterpart to the ADC capture path.
- Sits between the output FIFO read port and the DAC header pins.

Parameters:
- SCK_HALF, 2: clk cycles per SCK half-period (12.5 MHz SCK at 50 MHz clk).
- SAMPLE_PERIOD, 2500: clk cycles between sample ticks. Must be ≥ 16*2*SCK_HALF + SCK_HALF + 8.
- DAC_CMD, 4'b0011: command nibble prefixed to each frame (write and update).

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- en  in  1  stream enable
- fifo_out_readdata  in  32  FIFO q. Bits [15:0] are the signed sample; bits [31:16] are ignored.
- fifo_out_empty  in  1  FIFO empty
- fifo_out_read  out  1  FIFO read request; one-cycle pulse
- sck  out  1  DAC SPI clock (idle low)
- cs  out  1  DAC chip select (active low)
- din  out  1  DAC serial data (MSB first)
- underrun  out  1  sticky: a tick occurred while the FIFO was empty
- overrun  out  1  sticky: a tick occurred while a frame was in progress
- last_code  out  12  last code transmitted

Behaviour:
- Reset (synchronous, highest priority, applies mid-frame too): state=IDLE, tick counter=0, sck=0, cs=1, din=0, fifo_out_read=0, underrun=0, overrun=0, last_code=12'h800. Any frame in progress is aborted immediately.
- Tick counter:
  - Counts 0..SAMPLE_PERIOD-1 while en=1 and wraps; tick is asserted when count==SAMPLE_PERIOD-1.
  - When en=0 the counter is held at 0 and no ticks are generated.
- States: IDLE, FETCH, CAPTURE, SHIFT, TAIL.
- IDLE, on tick:
  - If !fifo_out_empty: go to FETCH.
  - Else: set underrun=1, reuse last_code, go directly to CAPTURE with no FIFO read.
- FETCH: fifo_out_read=1 for exactly this cycle. FIFO read latency is 1 (non-show-ahead). Go to CAPTURE.
- CAPTURE:
  - Takes fifo_out_readdata[15:0] as signed s, or last_code when in underrun.
  - Saturates s to [-2048, 2047], then code = s + 2048, 12 bits.
  - Loads shift register {DAC_CMD, code}, updates last_code = code, drives cs=0, sck=0, din=MSB. Go to SHIFT.
- SHIFT:
  - 16 bits, each 2*SCK_HALF cycles: sck low for SCK_HALF cycles, then high for SCK_HALF.
  - din changes only while sck is low, at the start of each bit. The DAC samples on the sck rising edge.
  - After the 16th high phase, sck returns low. Go to TAIL.
- TAIL: hold cs=0, sck=0 for SCK_HALF cycles, then cs=1. Go to IDLE.
- Frame timing:
  - From tick at cycle T: fifo_out_read at T+1, cs falls at T+3.
  - cs stays low for 16*2*SCK_HALF + SCK_HALF cycles (66 at default), with exactly 16 sck rising edges.
- Tick outside IDLE: overrun=1, tick dropped, current frame unaffected.
- en deasserted mid-frame:
  - The current frame completes normally; cs is never glitched.
  - A pending FETCH still performs its read and sends the frame.
  - No further ticks; sticky flags are held.
- Sticky flags clear only on reset.
- fifo_out_read is never asserted when fifo_out_empty was 1 in the preceding IDLE cycle.

Test Plan:
- SAMPLE_PERIOD=100, SCK_HALF=2. Reset, en=1, FIFO holds 0x00000000 → at the first tick, one fifo_out_read pulse; frame bits shifted out = 0x3800; last_code=0x800; cs low 66 cycles with 16 sck rising edges.
- FIFO holds 0xFFFFF800, 0x000007FF, 0x00001234, 0xFFFF8000, 0xABCD0001 over successive ticks → frames 0x3000, 0x3FFF, 0x3FFF (saturated), 0x3000 (saturated), 0x3801 (upper bits ignored).
- Send 0x00000100 (frame 0x3900), then leave the FIFO empty at the next tick → no fifo_out_read, frame 0x3900 repeated, underrun=1 and stays 1 afterwards.
- Set SAMPLE_PERIOD=40, shorter than a frame → overrun=1, every transmitted frame still complete (16 edges), no read issued for dropped ticks.
- Assert reset at bit 7 of a frame → next cycle cs=1, sck=0, din=0, last_code=0x800, flags 0; the next frame after a tick is correct.
- Drop en at bit 3 of a frame → frame completes with all 16 edges and cs rises normally; no further fifo_out_read while en=0; traffic resumes on re-enable after a full SAMPLE_PERIOD.
